int_res_addr_walker: RTL
========================

# int_res_addr_walker

Parametrised address sequencer for the intermediate-result CiM memory. It walks a 2D tensor region (rows × cols, programmable row stride, horizontal or vertical traversal, single- or double-width elements) from a base address. Each flat address is issued with its bank index and bank-local address over a valid/ready handshake. It sits between the inference-step controller, which supplies bases from the memory map, and the banked memory interface. It replaces per-step hand-coded address counters.

## Interface
- NUM_BANKS, 4, number of intermediate-result banks
- BANK_SIZE, 14336, words per bank
- ADDR_W, $clog2(NUM_BANKS*BANK_SIZE) (=16), flat address width
- LEN_W, $clog2(VECTOR_MAX_LEN+1) (=7), row/col count width
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a new walk; sampled only in IDLE
- base_addr  in  ADDR_W  flat start address
- num_rows  in  LEN_W  rows in region (0 allowed)
- num_cols  in  LEN_W  elements per row (0 allowed)
- row_stride  in  ADDR_W  word distance between row starts
- direction  in  1  Direction_t: HORIZONTAL = cols inner, VERTICAL = rows inner
- data_width  in  1  DataWidth_t: SINGLE_WIDTH step 1, DOUBLE_WIDTH step 2
- addr_ready  in  1  consumer accepts current address
- addr_valid  out  1  addr/bank_sel/bank_addr valid
- addr  out  ADDR_W  flat address
- bank_sel  out  $clog2(NUM_BANKS)  bank index
- bank_addr  out  $clog2(BANK_SIZE)  bank-local address
- last  out  1  current address is final element of walk
- busy  out  1  walk in progress (not IDLE)
- done  out  1  one-cycle pulse at walk completion or abort
- error  out  1  sticky out-of-range flag; cleared by next accepted start or rst

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: start=1 latches all config inputs. If num_rows==0 or num_cols==0, go to DONE with no addresses issued. Otherwise clear error, go to ISSUE.
- Element address = base_addr + r*row_stride + c*step, with step = 1 or 2.
  - Computed incrementally: row_base accumulator (+row_stride) and element offset accumulator (+step). No multipliers.
  - Internal sums use ADDR_W+1 bits.
- HORIZONTAL order: c inner (0..num_cols-1), r outer. VERTICAL order: r inner, c outer.
- Bank decomposition: bank_sel = addr / BANK_SIZE and bank_addr = addr − bank_sel*BANK_SIZE. Implemented with a NUM_BANKS-entry constant-threshold comparator chain (no divider).
- Range check: if addr + step − 1 ≥ NUM_BANKS*BANK_SIZE, or the internal sum overflows ADDR_W:
  - the element is not issued (addr_valid stays 0);
  - error is set and the FSM goes to DONE (abort).
- A double-width element may straddle a bank boundary. Only its first word is reported; the consumer handles the straddle.
- Advance occurs only on handshake (addr_valid & addr_ready). last=1 on the final element.
- DONE: done=1 for one cycle, then IDLE.
- start while busy: ignored, config unchanged.

## Timing
- Reset values: addr_valid=0, addr=0, bank_sel=0, bank_addr=0, last=0, busy=0, done=0, error=0; FSM in IDLE.
- rst mid-walk: next cycle is IDLE with all reset values. No done pulse; the partial walk is discarded.
- Outputs are registered.
  - First addr_valid is asserted the cycle after start is accepted.
  - Throughput is one address per cycle while addr_ready=1.
- Backpressure: while addr_valid=1 and addr_ready=0, addr, bank_sel, bank_addr and last are held stable.
- done pulses the cycle after the last handshake, or the cycle after abort/empty detection. busy is high from the cycle after start through the done cycle.
- New start is accepted the cycle after done (IDLE). Minimum gap between walks: 1 cycle.

## Test plan
- base 3840, 2×3, stride 64, SINGLE, HORIZONTAL, addr_ready=1 -> 3840,3841,3842,3904,3905,3906 on consecutive cycles; last on 3906; done next cycle; all in bank 0.
- Same config, VERTICAL -> 3840,3904,3841,3905,3842,3906.
- base 0, 1×3, DOUBLE -> 0,2,4. Then base 14335, 1×2, SINGLE -> (bank0,14335),(bank1,0).
- base 57340, 1×4, DOUBLE -> 57340 (bank3,14332), 57342 (bank3,14334) issued; third element not issued; error=1; done pulse; next valid start clears error.
- num_rows=0 -> no addr_valid, done one cycle after start. start during walk -> ignored.
- Random addr_ready toggling on a 4×4, stride 64 walk -> outputs stable while stalled, exactly 16 handshakes in order. rst asserted mid-walk -> all outputs 0, no done.

Source files
------------

// File: rtl/int_res_addr_walker.sv
// int_res_addr_walker
// Walks a 2D tensor region of the intermediate-result memory from a base
// address and issues each flat address, with its bank index and bank-local
// address, over a valid/ready handshake. Element address is
// base + r*row_stride + c*step. It is built up incrementally from a row-base
// accumulator and an element-offset accumulator, so no multiplier is needed.
// An element that would run past the end of the memory is not issued. It
// aborts the walk and sets the sticky error flag.
module int_res_addr_walker #(
    parameter int NUM_BANKS      = 4,
    parameter int BANK_SIZE      = 14336,
    parameter int VECTOR_MAX_LEN = 64,
    parameter int ADDR_W         = $clog2(NUM_BANKS * BANK_SIZE),
    parameter int LEN_W          = $clog2(VECTOR_MAX_LEN + 1),
    localparam int BANK_W        = $clog2(NUM_BANKS),
    localparam int BADDR_W       = $clog2(BANK_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   num_rows,
    input  logic [LEN_W-1:0]   num_cols,
    input  logic [ADDR_W-1:0]  row_stride,
    input  logic               direction,
    input  logic               data_width,
    input  logic               addr_ready,
    output logic               addr_valid,
    output logic [ADDR_W-1:0]  addr,
    output logic [BANK_W-1:0]  bank_sel,
    output logic [BADDR_W-1:0] bank_addr,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    typedef enum logic {HORIZONTAL = 1'b0, VERTICAL = 1'b1} direction_t;
    typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} data_width_t;

    localparam logic [ADDR_W:0] TOTAL_WORDS = (ADDR_W + 1)'(NUM_BANKS * BANK_SIZE);

    state_t            state;
    direction_t        dir_q;
    data_width_t       dw_q;
    logic [LEN_W-1:0]  rows_q, cols_q;
    logic [ADDR_W-1:0] base_q, stride_q;
    // Indices and accumulators of the element currently presented on addr.
    logic [LEN_W-1:0]  r_q, c_q;
    logic [ADDR_W:0]   rb_q, off_q;

    // Candidate for the next element to present
    logic [LEN_W-1:0]   cfg_rows, cfg_cols;
    logic [ADDR_W:0]    step;
    logic [LEN_W-1:0]   nxt_r, nxt_c;
    logic [ADDR_W:0]    nxt_rb, nxt_off, cand_sum, cand_end;
    logic               cand_ok, cand_last, handshake, empty_start, load_en;
    logic [BANK_W-1:0]  cand_bank;
    logic [BADDR_W-1:0] cand_baddr;

    // Next-element indices, address, range check and bank split
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cfg_rows = (state == IDLE) ? num_rows : rows_q;
        cfg_cols = (state == IDLE) ? num_cols : cols_q;
        if (state == IDLE)
            step = (data_width == DOUBLE_WIDTH) ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1);
        else
            step = (dw_q == DOUBLE_WIDTH) ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1);

        nxt_r   = r_q;
        nxt_c   = c_q;
        nxt_rb  = rb_q;
        nxt_off = off_q;
        if (state == IDLE) begin
            nxt_r   = '0;
            nxt_c   = '0;
            nxt_rb  = {1'b0, base_addr};
            nxt_off = '0;
        end else if (dir_q == HORIZONTAL) begin
            if (c_q == cols_q - LEN_W'(1)) begin
                nxt_c   = '0;
                nxt_off = '0;
                nxt_r   = r_q + LEN_W'(1);
                nxt_rb  = rb_q + {1'b0, stride_q};
            end else begin
                nxt_c   = c_q + LEN_W'(1);
                nxt_off = off_q + step;
            end
        end else begin
            if (r_q == rows_q - LEN_W'(1)) begin
                nxt_r   = '0;
                nxt_rb  = {1'b0, base_q};
                nxt_c   = c_q + LEN_W'(1);
                nxt_off = off_q + step;
            end else begin
                nxt_r   = r_q + LEN_W'(1);
                nxt_rb  = rb_q + {1'b0, stride_q};
            end
        end

        // The row base of an issued element always fits ADDR_W, so one
        // carry bit on either sum is enough to flag overflow.
        cand_sum  = nxt_rb + nxt_off;
        cand_end  = {1'b0, cand_sum[ADDR_W-1:0]} + step - (ADDR_W + 1)'(1);
        cand_ok   = !nxt_rb[ADDR_W] && !cand_sum[ADDR_W] && (cand_end < TOTAL_WORDS);
        cand_last = (nxt_r == cfg_rows - LEN_W'(1)) && (nxt_c == cfg_cols - LEN_W'(1));

        cand_bank  = '0;
        cand_baddr = BADDR_W'(cand_sum[ADDR_W-1:0]);
        for (int i = 1; i < NUM_BANKS; i++) begin
            if (cand_sum[ADDR_W-1:0] >= ADDR_W'(i * BANK_SIZE)) begin
                cand_bank  = BANK_W'(i);
                cand_baddr = BADDR_W'(cand_sum[ADDR_W-1:0] - ADDR_W'(i * BANK_SIZE));
            end
        end

        handshake   = (state == ISSUE) && addr_valid && addr_ready;
        empty_start = (num_rows == '0) || (num_cols == '0);
        load_en     = ((state == IDLE) && start && !empty_start) || (handshake && !last);
    end

    // Walk FSM with registered outputs
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            dir_q      <= HORIZONTAL;
            dw_q       <= SINGLE_WIDTH;
            rows_q     <= '0;
            cols_q     <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            r_q        <= '0;
            c_q        <= '0;
            rb_q       <= '0;
            off_q      <= '0;
            addr_valid <= 1'b0;
            addr       <= '0;
            bank_sel   <= '0;
            bank_addr  <= '0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q    <= direction_t'(direction);
                        dw_q     <= data_width_t'(data_width);
                        rows_q   <= num_rows;
                        cols_q   <= num_cols;
                        base_q   <= base_addr;
                        stride_q <= row_stride;
                        busy     <= 1'b1;
                        if (empty_start) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            error <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake && last) begin
                        addr_valid <= 1'b0;
                        last       <= 1'b0;
                        state      <= DONE;
                        done       <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Present the next element, or abort if it falls outside memory.
            if (load_en) begin
                if (cand_ok) begin
                    addr_valid <= 1'b1;
                    addr       <= cand_sum[ADDR_W-1:0];
                    bank_sel   <= cand_bank;
                    bank_addr  <= cand_baddr;
                    last       <= cand_last;
                    r_q        <= nxt_r;
                    c_q        <= nxt_c;
                    rb_q       <= nxt_rb;
                    off_q      <= nxt_off;
                    state      <= ISSUE;
                end else begin
                    addr_valid <= 1'b0;
                    last       <= 1'b0;
                    error      <= 1'b1;
                    done       <= 1'b1;
                    state      <= DONE;
                end
            end
        end
    end

endmodule
